parking_request_issuer: RTL and testbench
=========================================

Name: parking_request_issuer

Overview:
- Front-end transmitter for parking_lot_top's request interface.
- Assembles a 4-digit BCD plate from keypad digit strobes and queues entry/exit requests.
- Issues each request as a one-cycle in_mode/out_mode pulse with license_plate valid in that cycle, only while the lot core is idle.
- Sits between the keypad/board inputs and parking_lot_top; replaces hand-driven stimulus.

Parameters:
- FIFO_DEPTH, 4, request queue entries (power of 2, 2..8)
- TIMEOUT, 64, cycles to wait for core_busy after an issue before abandoning it

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; all state cleared while low
- digit  input  4  BCD keypad digit
- digit_valid  input  1  one-cycle digit strobe
- clear_key  input  1  discard the partial plate
- enter_key  input  1  queue an entry request for the assembled plate
- exit_key  input  1  queue an exit request for the assembled plate
- core_busy  input  1  lot core not in its idle state
- full_suv  input  1  from core
- full_sedan  input  1  from core
- license_plate  output  16  plate to core; 16'h0000 except in the issue cycle
- in_mode  output  1  one-cycle entry request
- out_mode  output  1  one-cycle exit request
- plate_ready  output  1  4 digits collected
- queue_count  output  4  FIFO occupancy
- req_dropped  output  1  one-cycle pulse: key rejected
- digit_error  output  1  one-cycle pulse: digit > 9, or digit while plate_ready
- timeout_err  output  1  one-cycle pulse: core never went busy

Behaviour:
- Reset state: all outputs 0; plate buffer 0; digit count 0; FIFO empty; FSM IDLE.
- Reset mid-operation clears everything immediately, including in-flight pulses.
- Assembler priority per cycle is clear_key > enter_key/exit_key > digit_valid.
- Valid digit (<=9) with count<4: buffer <= {buf[11:0], digit}, count+1.
- Invalid digit, or any digit with count==4: ignored, digit_error pulse.
- plate_ready = (count==4).
- Key push (enter or exit) is accepted only if all hold:
  - count==4
  - buffer != 16'h0000
  - FIFO not full
  - not both keys asserted
  - for enter, not (full_suv && full_sedan)
- Accepted push: writes {dir, plate} and clears buffer and count.
- Rejected key: req_dropped pulse; buffer is retained, except when rejected for both keys asserted.
- Simultaneous push and pop: both take effect, queue_count unchanged.
- FSM is IDLE -> ISSUE -> WAIT_BUSY -> WAIT_IDLE -> IDLE:
  - IDLE: FIFO non-empty and !core_busy -> ISSUE. Registered outputs drive the head entry (in_mode or out_mode = 1, license_plate = plate) for exactly the following cycle; pop happens at that same edge.
  - ISSUE: outputs return to 0 next edge -> WAIT_BUSY, timer cleared.
  - WAIT_BUSY: core_busy -> WAIT_IDLE. Timer reaching TIMEOUT-1 -> timeout_err pulse, -> IDLE (request lost).
  - WAIT_IDLE: !core_busy -> IDLE. Back-to-back issues are therefore separated by at least one idle-observed cycle.
- Minimum latency: key sampled at edge k, empty FIFO, idle core -> request pulse spans edge k+1 to k+2.
- Never asserts in_mode and out_mode together; never issues while core_busy was high at the decision edge.
- queue_count saturates at FIFO_DEPTH; no wrap corruption at pointer wrap-around.

Optional Feature:
- Macro REQ_DEDUP_EN.
- Defined: a push whose {dir, plate} equals any valid FIFO entry is rejected with req_dropped, and the buffer is cleared.
- Undefined: duplicates are queued and issued normally.

Decomposition:
- Shared package parking_pkg holds:
  - PLATE_W=16, DIGIT_W=4, BCD_MAX=9
  - direction encoding DIR_IN=0, DIR_OUT=1
  - issuer state encoding (IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE)
- Sub-module parking_req_fifo: synchronous FIFO of 17-bit {dir, plate}, FIFO_DEPTH entries, with count/full/empty and simultaneous push/pop; provides a match port for REQ_DEDUP_EN.

Test Plan:
- Digits 9,4,2,3 then enter_key, core_busy=0 -> one cycle later in_mode=1, license_plate=16'h9423 for exactly 1 cycle; queue_count 1->0.
- Queue 8754 enter then 8754 exit while core_busy=1 -> queue_count=2, no pulses. Release busy -> in_mode pulse 16'h8754. Core busy 5 cycles then idle -> out_mode pulse 16'h8754.
- Digit 4'hA, then a 5th digit after 1,2,3,4 -> digit_error pulses; buffer stays 16'h1234. Enter with 3 digits -> req_dropped, no push.
- Fill 4 requests with core_busy=1; 5th enter -> req_dropped, queue_count=4. full_suv=full_sedan=1 with an enter key -> req_dropped.
- Issue with core_busy held 0 -> timeout_err exactly TIMEOUT cycles after the pulse; FSM returns to IDLE and issues the next entry.
- Assert reset low during WAIT_IDLE with 3 queued -> all outputs 0 immediately, queue_count=0; after release no pulse until a new request is entered.

Source files
------------

// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared widths, direction encoding, request record and issuer
//            state encoding for the parking request issuer slice.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package parking_pkg;

  localparam int PLATE_W = 16;
  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;
  localparam int REQ_W   = PLATE_W + 1;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } issuer_state_t;

  // One queued request: direction in the MSB, BCD plate below it.
  typedef struct packed {
    logic               dir;
    logic [PLATE_W-1:0] plate;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/parking_request_issuer_if.sv
`default_nettype none
// ============================================================================
// Module   : parking_request_issuer_if
// Purpose  : Request bus between the issuer and the parking lot core.
// Signals  : license_plate[15:0], in_mode, out_mode  (issuer -> core)
//            core_busy, full_suv, full_sedan          (core -> issuer)
// Modports : master (issuer side), slave (core side)
// Revision : 1.0 - initial release
// ============================================================================
interface parking_request_issuer_if;

  logic [parking_pkg::PLATE_W-1:0] license_plate;
  logic                            in_mode;
  logic                            out_mode;
  logic                            core_busy;
  logic                            full_suv;
  logic                            full_sedan;

  modport master (
    output license_plate, in_mode, out_mode,
    input  core_busy, full_suv, full_sedan
  );

  modport slave (
    input  license_plate, in_mode, out_mode,
    output core_busy, full_suv, full_sedan
  );

endinterface
`default_nettype wire

// File: rtl/parking_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : parking_req_fifo
// Purpose  : Synchronous FIFO of {dir, plate} requests with occupancy count,
//            simultaneous push/pop and an associative match against all
//            currently valid entries.
// Ports    : clock, reset (async, active-low)
//            push, push_data        - write side
//            pop, head              - read side (head is show-ahead)
//            count, full, empty     - occupancy status
//            match_data, match      - 1 when match_data equals a valid entry
// Params   : FIFO_DEPTH (power of 2, 2..8)
// Revision : 1.0 - initial release
// ============================================================================
module parking_req_fifo
  import parking_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  req_t       push_data,
  input  logic       pop,
  output req_t       head,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  input  req_t       match_data,
  output logic       match
);

  localparam int AW = $clog2(FIFO_DEPTH);

  req_t                  r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [3:0]            r_count;
  logic [FIFO_DEPTH-1:0] r_valid;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [FIFO_DEPTH-1:0] w_valid_next;
  logic [FIFO_DEPTH-1:0] w_hit;

  assign empty     = (r_count == 4'd0);
  assign full      = (r_count == 4'(FIFO_DEPTH));
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign head      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Per-slot valid bits; clear-then-set so a push into the slot being popped
  // (full FIFO with simultaneous push/pop) leaves the slot valid.
  always_comb begin
    w_valid_next = r_valid;
    if (w_pop_ok)  w_valid_next[r_rd_ptr] = 1'b0;
    if (w_push_ok) w_valid_next[r_wr_ptr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      r_valid <= w_valid_next;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_match
    assign w_hit[gi] = r_valid[gi] && (r_mem[gi] == match_data);
  end

  assign match = |w_hit;

endmodule
`default_nettype wire

// File: rtl/parking_request_issuer.sv
`default_nettype none
// ============================================================================
// Module   : parking_request_issuer
// Purpose  : Assembles a 4-digit BCD plate from keypad strobes, queues
//            entry/exit requests and issues each one to the lot core as a
//            one-cycle in_mode/out_mode pulse while the core is idle.
// Ports    : clock, reset (async, active-low)
//            digit[3:0], digit_valid, clear_key, enter_key, exit_key - keypad
//            core (parking_request_issuer_if.master) - request bus to core
//            plate_ready, queue_count[3:0]           - status
//            req_dropped, digit_error, timeout_err   - one-cycle event pulses
// Params   : FIFO_DEPTH (power of 2, 2..8), TIMEOUT (>= 2)
// Macro    : REQ_DEDUP_EN - reject pushes identical to a queued request
// Revision : 1.0 - initial release
// ============================================================================
module parking_request_issuer
  import parking_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DIGIT_W-1:0]     digit,
  input  logic                   digit_valid,
  input  logic                   clear_key,
  input  logic                   enter_key,
  input  logic                   exit_key,
  parking_request_issuer_if.master core,
  output logic                   plate_ready,
  output logic [3:0]             queue_count,
  output logic                   req_dropped,
  output logic                   digit_error,
  output logic                   timeout_err
);

  localparam int TW = $clog2(TIMEOUT);

  // ---------------- plate assembler ----------------
  logic [PLATE_W-1:0] r_plate_buf;
  logic [2:0]         r_digit_cnt;
  logic               r_req_dropped;
  logic               r_digit_error;

  logic [PLATE_W-1:0] w_buf_next;
  logic [2:0]         w_cnt_next;
  logic               w_push;
  logic               w_dropped;
  logic               w_derr;
  logic               w_plate_full;
  logic               w_dup;
  req_t               w_push_data;

  // ---------------- FIFO ----------------
  req_t               w_head;
  logic [3:0]         w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_fifo_match;
  logic               w_pop;

  // ---------------- issuer FSM ----------------
  issuer_state_t      r_state;
  issuer_state_t      w_state_next;
  logic [TW-1:0]      r_timer;
  logic [TW-1:0]      w_timer_next;
  logic [TW-1:0]      w_timer_inc;
  logic               r_in_mode;
  logic               r_out_mode;
  logic [PLATE_W-1:0] r_plate_out;
  logic               r_timeout_err;
  logic               w_in_next;
  logic               w_out_next;
  logic [PLATE_W-1:0] w_plate_next;
  logic               w_to_next;

  assign w_plate_full      = (r_digit_cnt == 3'd4);
  assign w_push_data.dir   = exit_key ? DIR_OUT : DIR_IN;
  assign w_push_data.plate = r_plate_buf;

`ifdef REQ_DEDUP_EN
  assign w_dup = w_fifo_match;
`else
  logic w_unused_match;
  assign w_dup          = 1'b0;
  assign w_unused_match = w_fifo_match;
`endif

  // Priority: clear > enter/exit > digit.
  always_comb begin
    w_buf_next = r_plate_buf;
    w_cnt_next = r_digit_cnt;
    w_push     = 1'b0;
    w_dropped  = 1'b0;
    w_derr     = 1'b0;
    if (clear_key) begin
      w_buf_next = '0;
      w_cnt_next = '0;
    end else if (enter_key || exit_key) begin
      if (enter_key && exit_key) begin
        // Ambiguous key chord: discard the plate as well as the request.
        w_dropped  = 1'b1;
        w_buf_next = '0;
        w_cnt_next = '0;
      end else if (!w_plate_full || (r_plate_buf == '0) || w_fifo_full ||
                   (enter_key && core.full_suv && core.full_sedan)) begin
        w_dropped = 1'b1;
      end else if (w_dup) begin
        w_dropped  = 1'b1;
        w_buf_next = '0;
        w_cnt_next = '0;
      end else begin
        w_push     = 1'b1;
        w_buf_next = '0;
        w_cnt_next = '0;
      end
    end else if (digit_valid) begin
      if ((digit > DIGIT_W'(BCD_MAX)) || w_plate_full) begin
        w_derr = 1'b1;
      end else begin
        w_buf_next = {r_plate_buf[PLATE_W-DIGIT_W-1:0], digit};
        w_cnt_next = r_digit_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_plate_buf   <= '0;
      r_digit_cnt   <= '0;
      r_req_dropped <= 1'b0;
      r_digit_error <= 1'b0;
    end else begin
      r_plate_buf   <= w_buf_next;
      r_digit_cnt   <= w_cnt_next;
      r_req_dropped <= w_dropped;
      r_digit_error <= w_derr;
    end
  end

  parking_req_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (w_push),
    .push_data  (w_push_data),
    .pop        (w_pop),
    .head       (w_head),
    .count      (w_fifo_count),
    .full       (w_fifo_full),
    .empty      (w_fifo_empty),
    .match_data (w_push_data),
    .match      (w_fifo_match)
  );

  // The timer holds cycles spent in WAIT_BUSY; the abandon fires on the edge
  // at which it would reach TIMEOUT-1, which lands TIMEOUT cycles after the
  // start of the request pulse.
  assign w_timer_inc = r_timer + TW'(1);

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_in_next    = 1'b0;
    w_out_next   = 1'b0;
    w_plate_next = '0;
    w_to_next    = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty && !core.core_busy) begin
          w_pop        = 1'b1;
          w_in_next    = (w_head.dir == DIR_IN);
          w_out_next   = (w_head.dir == DIR_OUT);
          w_plate_next = w_head.plate;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_timer_next = '0;
        w_state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (core.core_busy) begin
          w_state_next = WAIT_IDLE;
        end else if (w_timer_inc == TW'(TIMEOUT - 1)) begin
          w_to_next    = 1'b1;
          w_timer_next = w_timer_inc;
          w_state_next = IDLE;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end
      WAIT_IDLE: begin
        if (!core.core_busy) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_in_mode     <= 1'b0;
      r_out_mode    <= 1'b0;
      r_plate_out   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_timer       <= w_timer_next;
      r_in_mode     <= w_in_next;
      r_out_mode    <= w_out_next;
      r_plate_out   <= w_plate_next;
      r_timeout_err <= w_to_next;
    end
  end

  assign core.license_plate = r_plate_out;
  assign core.in_mode       = r_in_mode;
  assign core.out_mode      = r_out_mode;
  assign plate_ready        = w_plate_full;
  assign queue_count        = w_fifo_count;
  assign req_dropped        = r_req_dropped;
  assign digit_error        = r_digit_error;
  assign timeout_err        = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_parking_request_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_request_issuer
// Purpose  : Directed self-checking bench for parking_request_issuer.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_request_issuer;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_valid = 1'b0;
  logic       clear_key = 1'b0;
  logic       enter_key = 1'b0;
  logic       exit_key = 1'b0;
  logic       plate_ready;
  logic [3:0] queue_count;
  logic       req_dropped;
  logic       digit_error;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  parking_request_issuer_if core_if ();

  parking_request_issuer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .digit       (digit),
    .digit_valid (digit_valid),
    .clear_key   (clear_key),
    .enter_key   (enter_key),
    .exit_key    (exit_key),
    .core        (core_if.master),
    .plate_ready (plate_ready),
    .queue_count (queue_count),
    .req_dropped (req_dropped),
    .digit_error (digit_error),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic key_digit(input logic [3:0] d);
    digit = d; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0; digit = 4'd0;
  endtask

  task automatic key_plate(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) key_digit(p[i*4 +: 4]);
  endtask

  task automatic key_enter();
    enter_key = 1'b1; tick(); enter_key = 1'b0;
  endtask

  task automatic key_exit();
    exit_key = 1'b1; tick(); exit_key = 1'b0;
  endtask

  task automatic key_clear();
    clear_key = 1'b1; tick(); clear_key = 1'b0;
  endtask

  // Core acknowledges an issued request: busy for two cycles, then idle.
  task automatic core_ack();
    core_if.core_busy = 1'b1; tick(); tick();
    core_if.core_busy = 1'b0; tick(); tick();
  endtask

  // Waits (bounded) for the next request pulse; flags stay 0 on expiry.
  task automatic wait_issue(input int max_cyc, output logic seen_in,
                            output logic seen_out, output logic [15:0] plate);
    seen_in = 1'b0; seen_out = 1'b0; plate = 16'h0;
    for (int i = 0; i < max_cyc; i++) begin
      if (core_if.in_mode || core_if.out_mode) begin
        seen_in  = core_if.in_mode;
        seen_out = core_if.out_mode;
        plate    = core_if.license_plate;
        return;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        s_in;
    logic        s_out;
    logic [15:0] s_plate;
    int          to_cyc;
    int          pulses;

    core_if.core_busy  = 1'b0;
    core_if.full_suv   = 1'b0;
    core_if.full_sedan = 1'b0;

    // ---- reset state ----
    tick(); tick();
    check_eq("rst_in_mode",   core_if.in_mode, 0);
    check_eq("rst_out_mode",  core_if.out_mode, 0);
    check_eq("rst_plate",     core_if.license_plate, 0);
    check_eq("rst_qcount",    queue_count, 0);
    check_eq("rst_ready",     plate_ready, 0);
    check_eq("rst_flags",     {req_dropped, digit_error, timeout_err}, 0);
    reset = 1'b1;
    tick();

    // ---- 9423 entry, minimum latency ----
    key_plate(16'h9423);
    check_eq("t1_ready", plate_ready, 1);
    key_enter();
    check_eq("t1_qc_push", queue_count, 1);
    check_eq("t1_not_yet", core_if.in_mode, 0);
    tick();
    check_eq("t1_in_mode", core_if.in_mode, 1);
    check_eq("t1_out_mode", core_if.out_mode, 0);
    check_eq("t1_plate", core_if.license_plate, 32'h9423);
    check_eq("t1_qc_pop", queue_count, 0);
    tick();
    check_eq("t1_in_end", core_if.in_mode, 0);
    check_eq("t1_plate_end", core_if.license_plate, 0);
    core_ack();

    // ---- 8754 entry + exit queued while busy ----
    core_if.core_busy = 1'b1;
    key_plate(16'h8754); key_enter();
    key_plate(16'h8754); key_exit();
    check_eq("t2_qc2", queue_count, 2);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (core_if.in_mode || core_if.out_mode) pulses++;
    end
    check_eq("t2_no_pulse_busy", pulses, 0);
    core_if.core_busy = 1'b0;
    wait_issue(10, s_in, s_out, s_plate);
    check_eq("t2_in_seen", {s_in, s_out}, 2'b10);
    check_eq("t2_in_plate", s_plate, 32'h8754);
    check_eq("t2_qc1", queue_count, 1);
    tick();
    core_if.core_busy = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (core_if.in_mode || core_if.out_mode) pulses++;
    end
    check_eq("t2_no_pulse_wait", pulses, 0);
    core_if.core_busy = 1'b0;
    wait_issue(10, s_in, s_out, s_plate);
    check_eq("t2_out_seen", {s_in, s_out}, 2'b01);
    check_eq("t2_out_plate", s_plate, 32'h8754);
    tick();
    check_eq("t2_out_end", core_if.out_mode, 0);
    check_eq("t2_qc0", queue_count, 0);
    core_ack();

    // ---- digit errors and short plate ----
    key_digit(4'hA);
    check_eq("t3_bad_digit", digit_error, 1);
    tick();
    check_eq("t3_err_one_cycle", digit_error, 0);
    key_plate(16'h1234);
    key_digit(4'd5);
    check_eq("t3_fifth_digit", digit_error, 1);
    check_eq("t3_still_ready", plate_ready, 1);
    key_enter();
    check_eq("t3_accept", req_dropped, 0);
    wait_issue(10, s_in, s_out, s_plate);
    check_eq("t3_in_seen", {s_in, s_out}, 2'b10);
    check_eq("t3_buf_kept", s_plate, 32'h1234);
    tick();
    core_ack();
    key_digit(4'd1); key_digit(4'd2); key_digit(4'd3);
    key_enter();
    check_eq("t3_short_drop", req_dropped, 1);
    check_eq("t3_short_qc", queue_count, 0);
    tick();
    check_eq("t3_drop_one_cycle", req_dropped, 0);
    key_clear();
    check_eq("t3_cleared", plate_ready, 0);

    // ---- lot full and FIFO full rejections ----
    core_if.core_busy = 1'b1;
    key_plate(16'h1111); key_enter();
    check_eq("t4_qc1", queue_count, 1);
    core_if.full_suv = 1'b1; core_if.full_sedan = 1'b1;
    key_plate(16'h6666); key_enter();
    check_eq("t4_lotfull_drop", req_dropped, 1);
    check_eq("t4_lotfull_qc", queue_count, 1);
    check_eq("t4_buf_retained", plate_ready, 1);
    key_exit();
    check_eq("t4_exit_ok", req_dropped, 0);
    check_eq("t4_qc2", queue_count, 2);
    core_if.full_suv = 1'b0; core_if.full_sedan = 1'b0;
    key_plate(16'h2222); key_enter();
    key_plate(16'h3333); key_enter();
    check_eq("t4_qc_full", queue_count, FIFO_DEPTH);
    key_plate(16'h5555); key_enter();
    check_eq("t4_full_drop", req_dropped, 1);
    check_eq("t4_qc_sat", queue_count, FIFO_DEPTH);
    key_clear();

    // ---- timeout when core never goes busy ----
    core_if.core_busy = 1'b0;
    wait_issue(10, s_in, s_out, s_plate);
    check_eq("t5_in_seen", {s_in, s_out}, 2'b10);
    check_eq("t5_plate", s_plate, 32'h1111);
    to_cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (timeout_err) begin
        to_cyc = i;
        break;
      end
    end
    check_eq("t5_timeout_cycle", to_cyc, TIMEOUT);
    tick();
    check_eq("t5_to_one_cycle", timeout_err, 0);
    check_eq("t5_next_out", core_if.out_mode, 1);
    check_eq("t5_next_plate", core_if.license_plate, 32'h6666);
    check_eq("t5_qc", queue_count, 2);

    // ---- reset during WAIT_IDLE with 3 queued ----
    core_if.core_busy = 1'b1;
    tick(); tick();
    key_plate(16'h7777); key_enter();
    check_eq("t6_qc3", queue_count, 3);
    key_digit(4'd9);
    reset = 1'b0;
    #1;
    check_eq("t6_rst_qc", queue_count, 0);
    check_eq("t6_rst_bus", {core_if.in_mode, core_if.out_mode, core_if.license_plate}, 0);
    check_eq("t6_rst_flags", {plate_ready, req_dropped, digit_error, timeout_err}, 0);
    tick();
    reset = 1'b1;
    core_if.core_busy = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (core_if.in_mode || core_if.out_mode) pulses++;
    end
    check_eq("t6_no_pulse_after", pulses, 0);
    key_plate(16'h4321); key_enter();
    wait_issue(10, s_in, s_out, s_plate);
    check_eq("t6_new_in", {s_in, s_out}, 2'b10);
    check_eq("t6_new_plate", s_plate, 32'h4321);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
